// File: rtl/spi_arb_if.sv
// Requester / SPI-master side bundle of the SPI arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface spi_arb_if;
  logic        req0;
  logic [15:0] cmd0;
  logic        req1;
  logic [15:0] cmd1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] rd_data;
  logic        err;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic        spi_ss_n;
  logic        ss0_n;
  logic        ss1_n;

  modport master (
    input  req0,
    input  cmd0,
    input  req1,
    input  cmd1,
    input  spi_done,
    input  spi_rd_data,
    input  spi_ss_n,
    output gnt0,
    output gnt1,
    output done0,
    output done1,
    output rd_data,
    output err,
    output spi_wrt,
    output spi_cmd,
    output ss0_n,
    output ss1_n
  );

  modport slave (
    output req0,
    output cmd0,
    output req1,
    output cmd1,
    output spi_done,
    output spi_rd_data,
    output spi_ss_n,
    input  gnt0,
    input  gnt1,
    input  done0,
    input  done1,
    input  rd_data,
    input  err,
    input  spi_wrt,
    input  spi_cmd,
    input  ss0_n,
    input  ss1_n
  );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one 16-bit SPI master between two requesters,
// with an inter-transaction gap, slave-select routing and a watchdog.
module spi_arb #(
  parameter int GAP  = 4,
  parameter int TO_W = 12
) (
  input logic      clk,
  input logic      rst_n,
  spi_arb_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  logic [1:0]      state;
  logic            last;
  logic [TO_W-1:0] wd;
  logic [GW-1:0]   gcnt;
  logic            wrt_q;
  logic            gnt0_q;
  logic            gnt1_q;
  logic            done0_q;
  logic            done1_q;
  logic            err_q;
  logic [15:0]     cmd_q;
  logic [15:0]     rd_q;

  logic any_req;
  logic pick1;
  logic fin;
  logic tmo;
  logic go;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick1   = bus.req1 & (~bus.req0 | ~last);
    fin     = done0_q | done1_q | err_q;
    tmo     = &wd;
    // The last GAP cycle doubles as IDLE entry, so requests are seen there
    go      = any_req &
              ((state == ST_IDLE) |
               ((state == ST_GAP) & (gcnt == GAP_LAST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last    <= 1'b1;
      wd      <= '0;
      gcnt    <= '0;
      wrt_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      rd_q    <= 16'h0000;
    end else begin
      wrt_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      if (go) begin
        cmd_q  <= pick1 ? bus.cmd1 : bus.cmd0;
        gnt0_q <= ~pick1;
        gnt1_q <= pick1;
        last   <= pick1;
        wrt_q  <= 1'b1;
        wd     <= '0;
        state  <= ST_BUSY;
      end else begin
        unique case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_BUSY: begin
            wd <= wd + 1'b1;
            // Grant is held through the done/err cycle, then released
            if (fin) begin
              gnt0_q <= 1'b0;
              gnt1_q <= 1'b0;
              gcnt   <= '0;
              state  <= ST_GAP;
            end else if (bus.spi_done) begin
              rd_q    <= bus.spi_rd_data;
              done0_q <= gnt0_q;
              done1_q <= gnt1_q;
            end else if (tmo) begin
              err_q <= 1'b1;
            end
          end
          ST_GAP: begin
            if (gcnt == GAP_LAST) state <= ST_IDLE;
            else gcnt <= gcnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.spi_wrt = wrt_q;
  assign bus.spi_cmd = cmd_q;
  assign bus.rd_data = rd_q;
  assign bus.ss0_n   = gnt0_q ? bus.spi_ss_n : 1'b1;
  assign bus.ss1_n   = gnt1_q ? bus.spi_ss_n : 1'b1;

endmodule
